alu_mc_exec: RTL and testbench

- Execute-stage ALU. It consumes the 5-bit ALU control code and Sign flag produced by the ALU control decoder, together with two 32-bit operands.
- Every operation except multiply completes in one cycle.
- Multiply (low 32 bits of the product) runs as a 32-iteration shift-add sequence and holds off new work until it finishes.
- The pipeline hazard unit uses busy/in_ready to stall ID/EX.

---
 rtl/alu_mc_exec.sv | 135 +++++++++++++
 tb/tb_alu_mc_exec.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc_exec.sv
`default_nettype none
// =============================================================================
// alu_mc_exec : execute-stage ALU, single-cycle ops plus shift-add multiply
// Rev 1.0
// =============================================================================
module alu_mc_exec #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [4:0]       ALUCtl,
  input  logic             Sign,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             flush,
  output logic             in_ready,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             Zero
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_OR  = 5'b00001;
  localparam logic [4:0] OP_ADD = 5'b00010;
  localparam logic [4:0] OP_GTZ = 5'b00011;
  localparam logic [4:0] OP_BNE = 5'b00100;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_SLT = 5'b00111;
  localparam logic [4:0] OP_NOR = 5'b01100;
  localparam logic [4:0] OP_XOR = 5'b01101;
  localparam logic [4:0] OP_SLL = 5'b10000;
  localparam logic [4:0] OP_SRL = 5'b11000;
  localparam logic [4:0] OP_SRA = 5'b11001;
  localparam logic [4:0] OP_MUL = 5'b11010;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO_W    = '0;

  logic [0:0]       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] acc_next;
  logic             accept;
  logic             lt;
  logic             gt_zero;

  assign in_ready = (state == S_IDLE);
  assign busy     = ~in_ready;
  // flush outranks a request arriving in the same cycle
  assign accept   = in_valid && in_ready && !flush;

  assign lt       = Sign ? ($signed(in1) < $signed(in2)) : (in1 < in2);
  assign gt_zero  = Sign ? ($signed(in1) > $signed(ZERO_W)) : (in1 != ZERO_W);
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  always_comb begin
    alu_res = '0;
    case (ALUCtl)
      OP_AND: alu_res = in1 & in2;
      OP_OR:  alu_res = in1 | in2;
      OP_ADD: alu_res = in1 + in2;
      OP_SUB: alu_res = in1 - in2;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, lt};
      OP_NOR: alu_res = ~(in1 | in2);
      OP_XOR: alu_res = in1 ^ in2;
      OP_SLL: alu_res = in2 << in1[4:0];
      OP_SRL: alu_res = in2 >> in1[4:0];
      OP_SRA: alu_res = $signed(in2) >>> in1[4:0];
      OP_GTZ: alu_res = {{(WIDTH-1){1'b0}}, ~gt_zero};
      OP_BNE: alu_res = {{(WIDTH-1){1'b0}}, (in1 == in2)};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      out       <= '0;
      Zero      <= 1'b0;
      out_valid <= 1'b0;
      count     <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (ALUCtl == OP_MUL) begin
              state  <= S_MUL;
              mcand  <= in1;
              mplier <= in2;
              acc    <= '0;
              count  <= '0;
            end else begin
              out       <= alu_res;
              Zero      <= (alu_res == ZERO_W);
              out_valid <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            // last iteration folds straight into the result registers
            if (count == LAST_ITER) begin
              out       <= acc_next;
              Zero      <= (acc_next == ZERO_W);
              out_valid <= 1'b1;
              state     <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_mc_exec.sv
`default_nettype none
// =============================================================================
// tb_alu_mc_exec : randomized and directed checks of alu_mc_exec against a model
// Rev 1.0
// =============================================================================
module tb_alu_mc_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [4:0]  ALUCtl;
  logic        Sign;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        flush;
  logic        in_ready;
  logic        busy;
  logic        out_valid;
  logic [31:0] out;
  logic        Zero;

  int n_pass  = 0;
  int n_total = 0;

  alu_mc_exec #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ALUCtl(ALUCtl), .Sign(Sign),
    .in1(in1), .in2(in2), .flush(flush), .in_ready(in_ready), .busy(busy),
    .out_valid(out_valid), .out(out), .Zero(Zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference: the opcode table evaluated directly, multiply as a plain product
  function automatic logic [31:0] model(input logic [4:0] c, input logic s,
                                        input logic [31:0] a, input logic [31:0] b);
    logic less, pos;
    less = s ? ($signed(a) < $signed(b)) : (a < b);
    pos  = s ? ($signed(a) > 32'sd0) : (a != 32'd0);
    case (c)
      5'b00000: return a & b;
      5'b00001: return a | b;
      5'b00010: return a + b;
      5'b00110: return a - b;
      5'b00111: return less ? 32'd1 : 32'd0;
      5'b01100: return ~(a | b);
      5'b01101: return a ^ b;
      5'b10000: return b << a[4:0];
      5'b11000: return b >> a[4:0];
      5'b11001: return $signed(b) >>> a[4:0];
      5'b00011: return pos ? 32'd0 : 32'd1;
      5'b00100: return (a == b) ? 32'd1 : 32'd0;
      5'b11010: return a * b;
      default:  return 32'd0;
    endcase
  endfunction

  // Drives one request; consecutive calls form back-to-back accepts
  task automatic single(input string tag, input logic [4:0] c, input logic s,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    exp = model(c, s, a, b);
    @(negedge clk);
    in_valid = 1'b1; ALUCtl = c; Sign = s; in1 = a; in2 = b; flush = 1'b0;
    @(posedge clk); #1;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_out"}, out, exp);
    check({tag, "_zero"}, {31'd0, Zero}, {31'd0, exp == 32'd0});
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_no_valid", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] prev, exp;
    logic        ok;
    prev = out;
    exp  = model(5'b11010, 1'b0, a, b);
    @(negedge clk);
    in_valid = 1'b1; ALUCtl = 5'b11010; Sign = 1'($urandom); in1 = a; in2 = b; flush = 1'b0;
    @(posedge clk); #1;
    ok = (in_ready === 1'b0) && (busy === 1'b1) && (out_valid === 1'b0) && (out === prev);
    // keep a competing ADD request up through the whole window
    @(negedge clk);
    ALUCtl = 5'b00010; in1 = 32'd1; in2 = 32'd1;
    repeat (31) begin
      @(posedge clk); #1;
      if (!((in_ready === 1'b0) && (busy === 1'b1) && (out_valid === 1'b0) && (out === prev)))
        ok = 1'b0;
    end
    check({tag, "_stall_window"}, {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_out"}, out, exp);
    check({tag, "_zero"}, {31'd0, Zero}, {31'd0, exp == 32'd0});
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    idle_cycle();
  endtask

  initial begin
    logic [4:0]  codes[13];
    logic [31:0] held;
    codes = '{5'b00000, 5'b00001, 5'b00010, 5'b00110, 5'b00111, 5'b01100, 5'b01101,
              5'b10000, 5'b11000, 5'b11001, 5'b00011, 5'b00100, 5'b01111};
    reset = 1'b1; in_valid = 1'b0; ALUCtl = '0; Sign = 1'b0; in1 = '0; in2 = '0; flush = 1'b0;
    #12;
    check("rst_out", out, 32'd0);
    check("rst_zero", {31'd0, Zero}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); reset = 1'b0;

    // Reset in the middle of a multiply
    single("pre", 5'b00010, 1'b0, 32'd40, 32'd2);
    @(negedge clk);
    in_valid = 1'b1; ALUCtl = 5'b11010; in1 = 32'd3; in2 = 32'd5;
    @(posedge clk); #1;
    @(negedge clk); in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midmul_rst_out", out, 32'd0);
    check("midmul_rst_zero", {31'd0, Zero}, 32'd0);
    check("midmul_rst_valid", {31'd0, out_valid}, 32'd0);
    check("midmul_rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); reset = 1'b0;

    // Directed single-cycle sweep, back-to-back
    single("add_ovf", 5'b00010, 1'b0, 32'h7FFF_FFFF, 32'd1);
    single("sub_eq", 5'b00110, 1'b0, 32'd5, 32'd5);
    single("slt_s", 5'b00111, 1'b1, 32'hFFFF_FFFF, 32'd1);
    single("slt_u", 5'b00111, 1'b0, 32'hFFFF_FFFF, 32'd1);
    single("sra", 5'b11001, 1'b0, 32'd4, 32'h8000_0000);
    single("nor", 5'b01100, 1'b0, 32'd0, 32'd0);
    single("gtz_pos", 5'b00011, 1'b1, 32'd7, 32'd0);
    single("gtz_neg", 5'b00011, 1'b1, 32'hFFFF_FFFF, 32'd0);
    single("bne", 5'b00100, 1'b0, 32'd4, 32'd9);
    single("unk", 5'b01111, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    single("add_b2b", 5'b00010, 1'b0, 32'd10, 32'd20);
    idle_cycle();

    run_mul("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_mul("mul_zero", 32'h0001_0000, 32'h0001_0000);

    // Flush a multiply at E15
    single("pre_flush", 5'b01101, 1'b0, 32'hA5A5_0000, 32'h0000_5A5A);
    held = out;
    @(negedge clk);
    in_valid = 1'b1; ALUCtl = 5'b11010; in1 = 32'd7; in2 = 32'd9;
    @(posedge clk); #1;
    @(negedge clk); in_valid = 1'b0;
    repeat (13) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    check("flush_ready", {31'd0, in_ready}, 32'd1);
    check("flush_no_valid", {31'd0, out_valid}, 32'd0);
    check("flush_out_kept", out, held);
    @(negedge clk); flush = 1'b0;
    @(posedge clk); #1;
    check("flush_no_late_valid", {31'd0, out_valid}, 32'd0);
    single("add_after_flush", 5'b00010, 1'b0, 32'd2, 32'd2);
    idle_cycle();

    // flush in IDLE blocks a concurrent request
    held = out;
    @(negedge clk);
    in_valid = 1'b1; ALUCtl = 5'b00010; in1 = 32'd100; in2 = 32'd1; flush = 1'b1;
    @(posedge clk); #1;
    check("idle_flush_valid", {31'd0, out_valid}, 32'd0);
    check("idle_flush_out", out, held);
    @(negedge clk); in_valid = 1'b0; flush = 1'b0;

    // Randomized back-to-back single-cycle ops
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 3) == 0) a = 32'(a[3:0]) - 32'd8;
      single("rnd", codes[$urandom_range(0, 12)], 1'($urandom), a, b);
    end
    idle_cycle();

    for (int i = 0; i < 3; i++) run_mul("rnd_mul", $urandom, $urandom);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
